mem_copy_engine: RTL and testbench

- Bus initiator that drives the data memory's single port to copy a block of bytes from a source address to a destination address.
- Each copy step is one read followed by one write, using the largest access size (4, 2 or 1 bytes) that keeps both addresses aligned.
- Sits beside the CPU datapath as a simple DMA; the memory port mux gives it ownership whenever busy is high.

---
 rtl/mem_copy_engine.sv | 179 +++++++++++++++++
 tb/tb_mem_copy_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: simple DMA-style block copier that owns the data memory's
// single port while busy is high.
//
// Each step reads one chunk from the source and writes it to the destination,
// using the largest access size (4, 2 or 1 bytes) that keeps both the current
// source and destination addresses aligned and does not exceed the bytes left.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   start            request pulse, only sampled while idle
//   src_addr         source byte address (sampled with start)
//   dst_addr         destination byte address (sampled with start)
//   byte_count       number of bytes to copy (sampled with start)
//   busy             high whenever the engine is not idle
//   done             one-cycle completion pulse
//   error            one-cycle pulse with done when the request was rejected
//   mem_address      memory byte address
//   mem_read_enable  memory read strobe
//   mem_write_enable memory write strobe
//   mem_write_data   write data, little-endian, byte 0 in [7:0]
//   mem_xfer_size    access size 1, 2 or 4; 0 when no access
//   mem_read_data    combinational read data from memory
module mem_copy_engine #(
  parameter int MEM_SIZE = 1024,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] byte_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      mem_address,
  output logic             mem_read_enable,
  output logic             mem_write_enable,
  output logic [31:0]      mem_write_data,
  output logic [2:0]       mem_xfer_size,
  input  logic [31:0]      mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [31:0]      data_q, data_d;
  logic [2:0]       sz_q, sz_d;
  logic             err_q, err_d;
  logic [2:0]       sz_now;

  // Bounds check is done at 33 bits so an address near 2^32 cannot wrap
  // around and slip past the memory-size limit.
  logic [32:0]      src_end, dst_end;

  function automatic logic [2:0] chunk_size(input logic [1:0]       s,
                                            input logic [1:0]       d,
                                            input logic [CNT_W-1:0] r);
    if (s == 2'b00 && d == 2'b00 && r >= CNT_W'(4)) begin
      return 3'd4;
    end else if (s[0] == 1'b0 && d[0] == 1'b0 && r >= CNT_W'(2)) begin
      return 3'd2;
    end else begin
      return 3'd1;
    end
  endfunction

  assign sz_now  = chunk_size(src_q[1:0], dst_q[1:0], rem_q);
  assign src_end = {1'b0, src_addr} + 33'(byte_count);
  assign dst_end = {1'b0, dst_addr} + 33'(byte_count);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      sz_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      sz_q    <= sz_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    sz_d    = sz_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          rem_d = byte_count;
          err_d = 1'b0;
          if (byte_count == '0) begin
            state_d = S_DONE;
          end else if (src_end > 33'(MEM_SIZE) || dst_end > 33'(MEM_SIZE)) begin
            // Rejected: report through DONE without touching memory.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        data_d  = mem_read_data;
        sz_d    = sz_now;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        src_d = src_q + 32'(sz_q);
        dst_d = dst_q + 32'(sz_q);
        rem_d = rem_q - CNT_W'(sz_q);
        if (rem_q == CNT_W'(sz_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs depend only on registered state, so the memory port never sees
  // a combinational path from the request inputs.
  always_comb begin
    busy             = (state_q != S_IDLE);
    done             = (state_q == S_DONE);
    error            = (state_q == S_DONE) && err_q;
    mem_address      = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    mem_xfer_size    = '0;
    case (state_q)
      S_READ: begin
        mem_read_enable = 1'b1;
        mem_address     = src_q;
        mem_xfer_size   = sz_now;
      end
      S_WRITE: begin
        mem_write_enable = 1'b1;
        mem_address      = dst_q;
        mem_xfer_size    = sz_q;
        mem_write_data   = data_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

  localparam int MEM_SIZE = 1024;
  localparam int CNT_W    = 11;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [CNT_W-1:0] byte_count;
  logic             busy, done, error;
  logic [31:0]      mem_address;
  logic             mem_read_enable, mem_write_enable;
  logic [31:0]      mem_write_data;
  logic [2:0]       mem_xfer_size;
  logic [31:0]      mem_read_data;

  mem_copy_engine #(.MEM_SIZE(MEM_SIZE), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .byte_count       (byte_count),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .mem_address      (mem_address),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_xfer_size    (mem_xfer_size),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] mem [MEM_SIZE];
  logic       init_req = 1'b0;
  int         seed = 0;

  function automatic logic [7:0] pat(input int i, input int s);
    return 8'((i * 13 + s * 29 + 5) ^ (i >> 3));
  endfunction

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= pat(i, seed);
    end else if (mem_write_enable) begin
      for (int k = 0; k < 4; k++)
        if (k < int'(mem_xfer_size))
          mem[(int'(mem_address) + k) & (MEM_SIZE - 1)] <= mem_write_data[8*k +: 8];
    end
  end

  always_comb begin
    mem_read_data = '0;
    for (int k = 0; k < 4; k++)
      if (k < int'(mem_xfer_size))
        mem_read_data[8*k +: 8] = mem[(int'(mem_address) + k) & (MEM_SIZE - 1)];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] data;
  } acc_t;

  acc_t       expq[$];
  logic [7:0] ref_mem [MEM_SIZE];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_mem(input int s);
    seed = s;
    init_req = 1'b1;
    @(posedge clk);
    #1 init_req = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = pat(i, s);
  endtask

  // Reference copy: ascending chunks, reads see earlier writes of the same copy.
  task automatic build_expect(input int s0, input int d0, input int cnt);
    int s, d, r, sz;
    logic [31:0] w;
    s = s0; d = d0; r = cnt;
    while (r > 0) begin
      if (s % 4 == 0 && d % 4 == 0 && r >= 4) sz = 4;
      else if (s % 2 == 0 && d % 2 == 0 && r >= 2) sz = 2;
      else sz = 1;
      w = '0;
      for (int k = 0; k < sz; k++) w[8*k +: 8] = ref_mem[s + k];
      expq.push_back('{wr: 1'b0, addr: 32'(s), sz: 3'(sz), data: 32'h0});
      expq.push_back('{wr: 1'b1, addr: 32'(d), sz: 3'(sz), data: w});
      for (int k = 0; k < sz; k++) ref_mem[d + k] = w[8*k +: 8];
      s += sz; d += sz; r -= sz;
    end
  endtask

  // Advance to the next falling edge and check any bus access of this cycle.
  task automatic tick();
    acc_t e;
    logic [31:0] mask;
    @(negedge clk);
    if (mem_read_enable && mem_write_enable) check("rd_wr_both", 1, 0);
    if (mem_read_enable || mem_write_enable) begin
      if (mem_xfer_size != 3'd1 && mem_xfer_size != 3'd2 && mem_xfer_size != 3'd4) begin
        check("xfer_size_legal", 64'(mem_xfer_size), 4);
      end else begin
        check("align", 64'(mem_address % 32'(mem_xfer_size)), 0);
        check("in_bounds", 64'(mem_address + 32'(mem_xfer_size) <= MEM_SIZE), 1);
      end
      if (expq.size() == 0) begin
        check("unexpected_access", 64'(mem_address), 64'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        check("acc_is_write", 64'(mem_write_enable), 64'(e.wr));
        check("acc_addr", 64'(mem_address), 64'(e.addr));
        check("acc_size", 64'(mem_xfer_size), 64'(e.sz));
        if (e.wr) begin
          mask = (e.sz == 3'd4) ? 32'hFFFF_FFFF : (e.sz == 3'd2) ? 32'h0000_FFFF : 32'h0000_00FF;
          check("wdata", 64'(mem_write_data & mask), 64'(e.data));
        end
      end
    end
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [CNT_W-1:0] c);
    src_addr = s; dst_addr = d; byte_count = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src_addr = $urandom; dst_addr = $urandom; byte_count = CNT_W'($urandom);
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  typedef struct {
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [CNT_W-1:0] cnt;
    logic             err;
    int               cyc;
  } vec_t;

  task automatic run_vec(input vec_t v, input int s);
    int n;
    bit got;
    load_mem(s);
    expq.delete();
    if (!v.err) build_expect(int'(v.src), int'(v.dst), int'(v.cnt));
    pulse_start(v.src, v.dst, v.cnt);
    n = 0; got = 0;
    while (!got && n < 600) begin
      tick();
      n++;
      if (n == 1) check("busy_after_start", 64'(busy), 1);
      if (done) got = 1;
    end
    check("done_cycle", 64'(n), 64'(v.cyc));
    check("error_flag", 64'(error), 64'(v.err));
    tick();
    check("done_one_cycle", 64'(done), 0);
    check("busy_idle", 64'(busy), 0);
    check("queue_empty", 64'(expq.size()), 0);
    check("mem_contents", 64'(mem_diffs()), 0);
  endtask

  vec_t vt[9];
  int   dones;
  int   n;

  initial begin
    vt[0] = '{src: 32'h000, dst: 32'h100, cnt: 11'd8,    err: 1'b0, cyc: 5};
    vt[1] = '{src: 32'h001, dst: 32'h101, cnt: 11'd7,    err: 1'b0, cyc: 7};
    vt[2] = '{src: 32'h002, dst: 32'h005, cnt: 11'd4,    err: 1'b0, cyc: 9};
    vt[3] = '{src: 32'h000, dst: 32'h200, cnt: 11'd0,    err: 1'b0, cyc: 1};
    vt[4] = '{src: 32'h3FC, dst: 32'h000, cnt: 11'd8,    err: 1'b1, cyc: 1};
    vt[5] = '{src: 32'h000, dst: 32'h3FE, cnt: 11'd4,    err: 1'b1, cyc: 1};
    vt[6] = '{src: 32'h3F8, dst: 32'h300, cnt: 11'd8,    err: 1'b0, cyc: 5};
    vt[7] = '{src: 32'h010, dst: 32'h020, cnt: 11'd3,    err: 1'b0, cyc: 5};
    vt[8] = '{src: 32'h000, dst: 32'h000, cnt: 11'd1025, err: 1'b1, cyc: 1};

    reset = 1'b1; start = 1'b0;
    src_addr = '0; dst_addr = '0; byte_count = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_error", 64'(error), 0);
    check("rst_rd_en", 64'(mem_read_enable), 0);
    check("rst_wr_en", 64'(mem_write_enable), 0);
    check("rst_addr", 64'(mem_address), 0);
    check("rst_wdata", 64'(mem_write_data), 0);
    check("rst_size", 64'(mem_xfer_size), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vt[i], i + 1);

    // start pulsed again mid-copy must be ignored
    load_mem(20);
    expq.delete();
    build_expect(32'h040, 32'h140, 8);
    pulse_start(32'h040, 32'h140, 11'd8);
    dones = 0;
    tick(); tick();
    src_addr = 32'h0; dst_addr = 32'h200; byte_count = 11'd16; start = 1'b1;
    if (done) dones++;
    tick();
    start = 1'b0;
    if (done) dones++;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dones++;
    end
    check("busy_ignore_done_count", 64'(dones), 1);
    check("busy_ignore_queue", 64'(expq.size()), 0);
    check("busy_ignore_mem", 64'(mem_diffs()), 0);

    // reset asserted during the first write aborts the copy
    load_mem(30);
    expq.delete();
    build_expect(32'h020, 32'h120, 8);
    pulse_start(32'h020, 32'h120, 11'd8);
    n = 0;
    while (!mem_write_enable && n < 10) begin
      tick();
      n++;
    end
    check("first_write_seen", 64'(mem_write_enable), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_wr_en", 64'(mem_write_enable), 0);
    check("async_rst_rd_en", 64'(mem_read_enable), 0);
    check("async_rst_busy", 64'(busy), 0);
    expq.delete();
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = pat(i, 30);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dones++;
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy) dones++;
    end
    check("no_done_after_reset", 64'(dones), 0);
    check("aborted_write_mem", 64'(mem_diffs()), 0);
    run_vec('{src: 32'h010, dst: 32'h110, cnt: 11'd4, err: 1'b0, cyc: 3}, 31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
